pc_fetch_unit: RTL and testbench

//  Program-counter stage directly upstream of the 16-bit sumador.
//  - Drives sumador.A with the current PC and sumador.B with the constant increment.
//  - Consumes sumador.C as the sequential next PC.
//  - Runs the request/ready handshake toward instruction memory.
//  - Applies stall and branch-redirect control from the pipeline.

---
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 tb/tb_pc_fetch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter / instruction fetch stage feeding the external sumador (optional: PC_ALIGN_CHECK_EN)
module pc_fetch_unit #(
   parameter int unsigned      WIDTH    = 16,
   parameter int unsigned      INC      = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic [WIDTH-1:0] add_c,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic [WIDTH-1:0] pc,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             fetch_valid,
   output logic [WIDTH-1:0] fetch_pc
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic             misalign
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] pc_next;
   logic             br_pend, br_pend_next;
   logic [WIDTH-1:0] br_tgt, br_tgt_next;
   logic             fv_next;
   logic [WIDTH-1:0] fpc_next;
   logic             tgt_load;

   // The sumador computes pc + INC outside this block
   assign add_a = pc;
   assign add_b = WIDTH'(INC);

   // Next-state, next-pc and handshake decode
   always_comb begin
      state_next   = state;
      pc_next      = pc;
      br_pend_next = br_pend;
      br_tgt_next  = br_tgt;
      fv_next      = 1'b0;
      fpc_next     = fetch_pc;
      tgt_load     = 1'b0;
      imem_req     = 1'b0;
      case (state)
         S_IDLE, S_HOLD: begin
            // Redirects are honoured even while stalled
            if (branch_taken) begin
               pc_next  = branch_target;
               tgt_load = 1'b1;
            end
            if (!stall) state_next = S_REQ;
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               fpc_next     = pc;
               br_pend_next = 1'b0;
               if (branch_taken) begin
                  pc_next  = branch_target;
                  tgt_load = 1'b1;
               end else if (br_pend) begin
                  pc_next  = br_tgt;
                  tgt_load = 1'b1;
               end else begin
                  pc_next = add_c;
                  fv_next = 1'b1;
               end
               if (stall) state_next = S_HOLD;
            end else if (branch_taken) begin
               // pc must stay put until the request is accepted; remember the redirect
               br_pend_next = 1'b1;
               br_tgt_next  = branch_target;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         br_pend     <= 1'b0;
         br_tgt      <= '0;
         fetch_valid <= 1'b0;
         fetch_pc    <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         br_pend     <= br_pend_next;
         br_tgt      <= br_tgt_next;
         fetch_valid <= fv_next;
         fetch_pc    <= fpc_next;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   // Sticky flag: any redirect target that is not word aligned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign <= 1'b0;
      else if (tgt_load && (pc_next[1:0] != 2'b00)) misalign <= 1'b1;
   end
`else
   logic unused_tgt_load;
   assign unused_tgt_load = tgt_load;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed table-driven bench for pc_fetch_unit
module tb_pc_fetch_unit;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         stall = 1'b0;
   logic         branch_taken = 1'b0;
   logic [W-1:0] branch_target = '0;
   logic         imem_ready = 1'b0;

   logic [W-1:0] add_a0, add_b0, add_c0, pc0, fpc0;
   logic         req0, fv0;
   logic [W-1:0] add_a1, add_b1, add_c1, pc1, fpc1;
   logic         req1, fv1;
`ifdef PC_ALIGN_CHECK_EN
   logic         mis0, mis1;
`endif

   int total = 0;
   int bad   = 0;

   // Behavioural sumadors
   assign add_c0 = add_a0 + add_b0;
   assign add_c1 = add_a1 + add_b1;

   pc_fetch_unit #(.WIDTH(W), .INC(4), .RESET_PC(16'h0000)) dut0 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .add_c(add_c0), .add_a(add_a0), .add_b(add_b0),
      .pc(pc0), .imem_req(req0), .imem_ready(imem_ready), .fetch_valid(fv0),
      .fetch_pc(fpc0)
`ifdef PC_ALIGN_CHECK_EN
      , .misalign(mis0)
`endif
   );

   pc_fetch_unit #(.WIDTH(W), .INC(4), .RESET_PC(16'hFFF8)) dut1 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .add_c(add_c1), .add_a(add_a1), .add_b(add_b1),
      .pc(pc1), .imem_req(req1), .imem_ready(imem_ready), .fetch_valid(fv1),
      .fetch_pc(fpc1)
`ifdef PC_ALIGN_CHECK_EN
      , .misalign(mis1)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         stall;
      logic         br;
      logic [W-1:0] tgt;
      logic         rdy;
      logic [W-1:0] pc;
      logic         req;
      logic         fv;
      logic [W-1:0] fpc;
      logic [W-1:0] pc1;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic s, input logic b, input logic [W-1:0] t, input logic r,
                          input logic [W-1:0] p, input logic q, input logic v,
                          input logic [W-1:0] fp, input logic [W-1:0] p1);
      vec_t x;
      x.stall = s; x.br = b; x.tgt = t; x.rdy = r;
      x.pc = p; x.req = q; x.fv = v; x.fpc = fp; x.pc1 = p1;
      vecs.push_back(x);
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      // Outputs shown are those present before the inputs of the same row are applied
      //       stall br tgt      rdy  pc       req fv fpc      pc(RESET_PC=FFF8)
      add_vec(0, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'hFFF8); // 0 idle after reset
      add_vec(0, 0, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000, 16'hFFF8); // 1
      add_vec(0, 0, 16'h0000, 1, 16'h0004, 1, 1, 16'h0000, 16'hFFFC); // 2
      add_vec(0, 0, 16'h0000, 0, 16'h0008, 1, 1, 16'h0004, 16'h0000); // 3 ready low x3
      add_vec(0, 0, 16'h0000, 0, 16'h0008, 1, 0, 16'h0004, 16'h0000); // 4
      add_vec(0, 0, 16'h0000, 0, 16'h0008, 1, 0, 16'h0004, 16'h0000); // 5
      add_vec(0, 0, 16'h0000, 1, 16'h0008, 1, 0, 16'h0004, 16'h0000); // 6
      add_vec(0, 0, 16'h0000, 1, 16'h000C, 1, 1, 16'h0008, 16'h0004); // 7
      add_vec(0, 1, 16'h0100, 0, 16'h0010, 1, 1, 16'h000C, 16'h0008); // 8 branch, not accepted
      add_vec(0, 0, 16'h0000, 1, 16'h0010, 1, 0, 16'h000C, 16'h0008); // 9 accept, pending wins
      add_vec(0, 0, 16'h0000, 1, 16'h0100, 1, 0, 16'h0010, 16'h0100); // 10 fetch at 16 squashed
      add_vec(0, 1, 16'h0010, 1, 16'h0104, 1, 1, 16'h0100, 16'h0104); // 11 accept + branch
      add_vec(1, 0, 16'h0000, 1, 16'h0010, 1, 0, 16'h0104, 16'h0010); // 12 accept + stall
      add_vec(1, 0, 16'h0000, 1, 16'h0014, 0, 1, 16'h0010, 16'h0014); // 13 hold
      add_vec(1, 0, 16'h0000, 1, 16'h0014, 0, 0, 16'h0010, 16'h0014); // 14 hold
      add_vec(0, 0, 16'h0000, 1, 16'h0014, 0, 0, 16'h0010, 16'h0014); // 15 release
      add_vec(0, 0, 16'h0000, 1, 16'h0014, 1, 0, 16'h0010, 16'h0014); // 16 resume at 20
      add_vec(1, 0, 16'h0000, 1, 16'h0018, 1, 1, 16'h0014, 16'h0018); // 17
      add_vec(1, 1, 16'h0040, 1, 16'h001C, 0, 1, 16'h0018, 16'h001C); // 18 branch in hold
      add_vec(0, 0, 16'h0000, 1, 16'h0040, 0, 0, 16'h0018, 16'h0040); // 19
      add_vec(0, 0, 16'h0000, 1, 16'h0040, 1, 0, 16'h0018, 16'h0040); // 20
      add_vec(1, 0, 16'h0000, 0, 16'h0044, 1, 1, 16'h0040, 16'h0044); // 21 stall cannot drop req
      add_vec(0, 0, 16'h0000, 0, 16'h0044, 1, 0, 16'h0040, 16'h0044); // 22

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_pc", pc0, 16'h0000);
      check("reset_req", {15'd0, req0}, 16'd0);
      check("reset_pc1", pc1, 16'hFFF8);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("v%0d pc", i), pc0, vecs[i].pc);
         check($sformatf("v%0d add_a", i), add_a0, vecs[i].pc);
         check($sformatf("v%0d add_b", i), add_b0, 16'd4);
         check($sformatf("v%0d req", i), {15'd0, req0}, {15'd0, vecs[i].req});
         check($sformatf("v%0d fv", i), {15'd0, fv0}, {15'd0, vecs[i].fv});
         check($sformatf("v%0d fpc", i), fpc0, vecs[i].fpc);
         check($sformatf("v%0d pc_wrap", i), pc1, vecs[i].pc1);
         stall         = vecs[i].stall;
         branch_taken  = vecs[i].br;
         branch_target = vecs[i].tgt;
         imem_ready    = vecs[i].rdy;
      end

      // Asynchronous reset in the middle of a completing handshake
      @(negedge clk);
      stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
      @(posedge clk); #1;
      check("pre_rst_fv", {15'd0, fv0}, 16'd1);
      check("pre_rst_pc", pc0, 16'h0048);
      #2 rst_n = 1'b0;
      #1;
      check("async_req", {15'd0, req0}, 16'd0);
      check("async_fv", {15'd0, fv0}, 16'd0);
      check("async_pc", pc0, 16'h0000);
      check("async_fpc", fpc0, 16'h0000);
      check("async_pc1", pc1, 16'hFFF8);
      @(negedge clk);
      stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0102;
      rst_n = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
      check("mis_reset", {15'd0, mis0}, 16'd0);
`endif
      @(negedge clk);
      branch_taken = 1'b0;
      check("idle_branch_pc", pc0, 16'h0102);
      check("idle_stall_req", {15'd0, req0}, 16'd0);
`ifdef PC_ALIGN_CHECK_EN
      check("mis_set", {15'd0, mis0}, 16'd1);
      branch_taken = 1'b1; branch_target = 16'h0200;
      @(negedge clk);
      branch_taken = 1'b0;
      check("mis_sticky", {15'd0, mis0}, 16'd1);
      rst_n = 1'b0;
      #1;
      check("mis_clear", {15'd0, mis0}, 16'd0);
      rst_n = 1'b1;
`endif
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
